rll_rx_frame_ctrl: RTL

Receive-side controller that sequences the RLL(2,7) decoder and frames its output. It enables the decoder and hunts for a sync word in the variable-length decoded bit groups (2, 3 or 4 bits). It then packs a fixed-length payload into bytes and delivers them through a small FIFO with a valid/ready handshake. It sits between the decoder and the byte-level consumer (CRC/deframer), and reports sync timeout and overflow.

---
 rtl/rll_rx_pkg.sv | 22 ++
 rtl/rll_byte_fifo.sv | 61 ++++++
 rtl/rll_rx_frame_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rll_rx_pkg.sv
// Shared types and constants for the RLL(2,7) receive framing controller.
// Contents: FSM state enum, legal decoded-group length range, accumulator sizing,
// and a helper that tests whether a group length is legal.
package rll_rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HUNT    = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  localparam int unsigned LEN_MIN   = 2;
  localparam int unsigned LEN_MAX   = 4;
  localparam int unsigned ACC_W     = 12;
  localparam int unsigned ACC_CNT_W = 4;

  // True when a decoded group length is within the legal 2..4 range.
  function automatic logic len_ok(input logic [2:0] len);
    return (len >= 3'(LEN_MIN)) && (len <= 3'(LEN_MAX));
  endfunction

endpackage

// File: rtl/rll_byte_fifo.sv
// Small synchronous first-word-fall-through FIFO for payload bytes.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored when full unless popping)
//   pop        : read request (ignored when empty)
//   dout       : head entry, valid whenever empty is low
//   full/empty : occupancy flags
module rll_byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push_c;
  logic             do_pop_c;

  // A full FIFO still accepts a write when the head is leaving the same cycle.
  assign do_pop_c  = pop && (count != '0);
  assign do_push_c = push && ((count != CW'(DEPTH)) || do_pop_c);

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push_c) - CW'(do_pop_c);
    end
  end

endmodule

// File: rtl/rll_rx_frame_ctrl.sv
// Receive framing controller behind the RLL(2,7) decoder: enables the decoder,
// hunts for the sync word across variable-length decoded groups, packs the
// fixed-length payload into bytes and hands them out through a byte FIFO.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   start, abort                : begin a receive attempt / return to idle
//   dec_en                      : decoder enable (high in HUNT and PAYLOAD)
//   dec_valid, dec_len, dec_bits: decoded group, right-aligned, MSB oldest
//   byte_data, byte_valid,
//   byte_ready                  : payload byte stream, valid/ready handshake
//   frame_start, frame_done     : one-cycle pulses on sync match / last byte
//   busy                        : controller not idle
//   sync_timeout, ovf_err,
//   len_err                     : sticky status, cleared by start
module rll_rx_frame_ctrl
  import rll_rx_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD    = 16'hA1F3,
  parameter int unsigned FRAME_BYTES  = 16,
  parameter int unsigned HUNT_TIMEOUT = 1024,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       dec_en,
  input  logic       dec_valid,
  input  logic [2:0] dec_len,
  input  logic [3:0] dec_bits,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       frame_start,
  output logic       frame_done,
  output logic       busy,
  output logic       sync_timeout,
  output logic       ovf_err,
  output logic       len_err
);

  localparam int unsigned GRP_W  = $clog2(HUNT_TIMEOUT + 1);
  localparam int unsigned BCNT_W = 8;

  state_t               state_q, state_d;
  logic [15:0]          win_q, win_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [ACC_CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [BCNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [GRP_W-1:0]     grp_cnt_q, grp_cnt_d;
  logic                 frame_start_d, frame_done_d;
  logic                 sync_timeout_d, ovf_err_d, len_err_d;

  logic                 matched_c;
  logic                 grp_bit_c;
  logic [3:0]           bits_m_c;
  logic [7:0]           byte_c;
  logic                 push_c;
  logic [7:0]           push_data_c;
  logic                 pop_c;
  logic                 fifo_full_c;
  logic                 fifo_empty_c;

  assign byte_valid = ~fifo_empty_c;
  assign pop_c      = byte_valid & byte_ready;

  rll_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .din   (push_data_c),
    .pop   (pop_c),
    .dout  (byte_data),
    .full  (fifo_full_c),
    .empty (fifo_empty_c)
  );

  // Next-state, sync search and byte packing.
  always_comb begin
    state_d        = state_q;
    win_d          = win_q;
    acc_d          = acc_q;
    acc_cnt_d      = acc_cnt_q;
    byte_cnt_d     = byte_cnt_q;
    grp_cnt_d      = grp_cnt_q;
    frame_start_d  = 1'b0;
    frame_done_d   = 1'b0;
    sync_timeout_d = sync_timeout;
    ovf_err_d      = ovf_err;
    len_err_d      = len_err;
    matched_c      = 1'b0;
    grp_bit_c      = 1'b0;
    byte_c         = '0;
    push_c         = 1'b0;
    push_data_c    = '0;
    // Upper bits of a short group are don't-care; keep them out of the accumulator.
    bits_m_c       = dec_bits & 4'((5'd1 << dec_len) - 5'd1);

    if (abort) begin
      state_d   = IDLE;
      acc_d     = '0;
      acc_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d        = HUNT;
            sync_timeout_d = 1'b0;
            ovf_err_d      = 1'b0;
            len_err_d      = 1'b0;
            win_d          = '0;
            acc_d          = '0;
            acc_cnt_d      = '0;
            byte_cnt_d     = '0;
            grp_cnt_d      = '0;
          end
        end

        HUNT: begin
          if (dec_valid) begin
            if (!len_ok(dec_len)) begin
              len_err_d = 1'b1;
            end else begin
              grp_cnt_d = grp_cnt_q + GRP_W'(1);
              acc_d     = '0;
              acc_cnt_d = '0;
              // Bit-serial walk, oldest first; bits after the match start the payload.
              for (int i = 0; i < int'(LEN_MAX); i++) begin
                if (i < int'(dec_len)) begin
                  grp_bit_c = dec_bits[2'(int'(dec_len) - 1 - i)];
                  if (matched_c) begin
                    acc_d     = {acc_d[ACC_W-2:0], grp_bit_c};
                    acc_cnt_d = acc_cnt_d + ACC_CNT_W'(1);
                  end else begin
                    win_d = {win_d[14:0], grp_bit_c};
                    if (win_d == SYNC_WORD) begin
                      matched_c = 1'b1;
                    end
                  end
                end
              end
              if (matched_c) begin
                state_d       = PAYLOAD;
                frame_start_d = 1'b1;
                byte_cnt_d    = '0;
              end else if (grp_cnt_d >= GRP_W'(HUNT_TIMEOUT)) begin
                sync_timeout_d = 1'b1;
                state_d        = IDLE;
              end
            end
          end
        end

        PAYLOAD: begin
          if (dec_valid) begin
            if (!len_ok(dec_len)) begin
              len_err_d = 1'b1;
            end else begin
              acc_d     = (acc_q << dec_len) | ACC_W'(bits_m_c);
              acc_cnt_d = acc_cnt_q + ACC_CNT_W'(dec_len);
              if (acc_cnt_d >= ACC_CNT_W'(8)) begin
                // Oldest 8 of the valid bits; anything above them is stale.
                byte_c    = 8'(acc_d >> (acc_cnt_d - ACC_CNT_W'(8)));
                acc_cnt_d = acc_cnt_d - ACC_CNT_W'(8);
                if (fifo_full_c && !pop_c) begin
                  ovf_err_d = 1'b1;
                  state_d   = HUNT;
                  win_d     = '0;
                  grp_cnt_d = '0;
                  acc_d     = '0;
                  acc_cnt_d = '0;
                end else begin
                  push_c      = 1'b1;
                  push_data_c = byte_c;
                  byte_cnt_d  = byte_cnt_q + BCNT_W'(1);
                  if (byte_cnt_d == BCNT_W'(FRAME_BYTES)) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                    acc_d        = '0;
                    acc_cnt_d    = '0;
                  end
                end
              end
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      win_q        <= '0;
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      grp_cnt_q    <= '0;
      dec_en       <= 1'b0;
      busy         <= 1'b0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
      sync_timeout <= 1'b0;
      ovf_err      <= 1'b0;
      len_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      grp_cnt_q    <= grp_cnt_d;
      dec_en       <= (state_d != IDLE);
      busy         <= (state_d != IDLE);
      frame_start  <= frame_start_d;
      frame_done   <= frame_done_d;
      sync_timeout <= sync_timeout_d;
      ovf_err      <= ovf_err_d;
      len_err      <= len_err_d;
    end
  end

endmodule
